// File: rtl/ui_pkg.sv
// Shared types for the on-screen overlay sequencer.
package ui_pkg;

  localparam int unsigned MSG_COUNT = 3;

  // Message ids double as pending-bit indices; lower index = higher priority.
  typedef enum logic [1:0] {
    MSG_TURBO   = 2'd0,
    MSG_SAVE    = 2'd1,
    MSG_PALETTE = 2'd2
  } msg_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SHOW = 2'd2
  } state_e;

endpackage

// File: rtl/ui_msg_arbiter.sv
// Fixed-priority picker over the pending overlay requests.
module ui_msg_arbiter
  import ui_pkg::*;
(
  input  logic [MSG_COUNT-1:0] pending,
  input  msg_id_e              cur_id,
  output logic                 any,
  output msg_id_e              winner,
  output logic                 higher
);

  // Lowest pending index wins; higher flags a request outranking cur_id.
  always_comb begin
    any    = |pending;
    winner = MSG_TURBO;
    if (pending[0]) begin
      winner = MSG_TURBO;
    end else if (pending[1]) begin
      winner = MSG_SAVE;
    end else if (pending[2]) begin
      winner = MSG_PALETTE;
    end
    case (cur_id)
      MSG_TURBO:   higher = 1'b0;
      MSG_SAVE:    higher = pending[0];
      MSG_PALETTE: higher = |pending[1:0];
      default:     higher = 1'b0;
    endcase
  end

endmodule

// File: rtl/ui_overlay_ctrl.sv
// Overlay sequencer: latches requests, arbitrates, aligns display to frame starts and
// holds each message visible for HOLD_FRAMES frames.
module ui_overlay_ctrl
  import ui_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [2:0] turbo_speed,
  input  logic [1:0] ext_req,
  output logic       overlay_en,
  output logic [1:0] msg_id,
  output logic [2:0] speed_shown,
  output logic [2:0] pending
);

  localparam int unsigned CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] HoldLoad = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0] CntOne   = CW'(1);

  state_e                 state_q, state_d;
  msg_id_e                msg_id_q, msg_id_d;
  logic [2:0]             speed_q, speed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic [MSG_COUNT-1:0]   pend_q, pend_d, pend_set, pend_clr;
  logic [2:0]             prev_speed_q;
  logic                   primed_q;

  logic    arb_any;
  msg_id_e arb_winner;
  logic    arb_higher;

  ui_msg_arbiter u_arb (
    .pending (pend_q),
    .cur_id  (msg_id_q),
    .any     (arb_any),
    .winner  (arb_winner),
    .higher  (arb_higher)
  );

  // New requests; the unprimed first cycle after reset never raises MSG_TURBO.
  always_comb begin
    pend_set    = {ext_req, primed_q && (turbo_speed != prev_speed_q)};
    pend_d      = (pend_q & ~pend_clr) | pend_set;
  end

  // Change detector and pending request register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_speed_q <= 3'd0;
      primed_q     <= 1'b0;
      pend_q       <= '0;
    end else begin
      prev_speed_q <= turbo_speed;
      primed_q     <= 1'b1;
      pend_q       <= pend_d;
    end
  end

  // FSM next state, frame counter, message and speed latches.
  always_comb begin
    state_d  = state_q;
    msg_id_d = msg_id_q;
    speed_d  = speed_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        cnt_d = '0;
        if (arb_any) begin
          msg_id_d = arb_winner;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (frame_start) begin
          if (arb_any) begin
            // Re-pick here so a higher request arriving while armed takes over.
            msg_id_d             = arb_winner;
            pend_clr[arb_winner] = 1'b1;
            if (arb_winner == MSG_TURBO) speed_d = turbo_speed;
            cnt_d   = HoldLoad;
            en_d    = 1'b1;
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SHOW: begin
        if (frame_start) begin
          if (pend_q[msg_id_q]) begin
            pend_clr[msg_id_q] = 1'b1;
            cnt_d              = HoldLoad;
            if (msg_id_q == MSG_TURBO) speed_d = turbo_speed;
          end else if (arb_higher) begin
            msg_id_d             = arb_winner;
            pend_clr[arb_winner] = 1'b1;
            cnt_d                = HoldLoad;
            if (arb_winner == MSG_TURBO) speed_d = turbo_speed;
          end else if (cnt_q == CntOne) begin
            // Counter parks at 1 when re-arming; IDLE zeroes it.
            en_d    = 1'b0;
            state_d = arb_any ? ARM : IDLE;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      msg_id_q <= MSG_TURBO;
      speed_q  <= 3'd0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_id_q <= msg_id_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
    end
  end

  assign overlay_en  = en_q;
  assign msg_id      = msg_id_q;
  assign speed_shown = speed_q;
  assign pending     = pend_q;

endmodule
